// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM states, read source encoding
// and the pending-read entry carried through the in-order tracking FIFO.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RD_REQ = 2'd1,
      WR_REQ = 2'd2
   } arb_state_e;

   localparam logic SRC_INST = 1'b0;
   localparam logic SRC_DATA = 1'b1;

   typedef struct packed {
      logic        src;
      logic [31:0] addr;
   } pend_entry_t;

endpackage

// File: rtl/mem_arb_pend_fifo.sv
// In-order tracker of outstanding reads; the head names the channel and address
// that the next memory read response belongs to.
module mem_arb_pend_fifo
   import mem_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        i_push,
   input  logic        i_src,
   input  logic [31:0] i_addr,
   input  logic        i_pop,
   output logic        o_full,
   output logic        o_empty,
   output logic        o_head_src,
   output logic [31:0] o_head_addr
);

   localparam int unsigned PtrW = $clog2(DEPTH);

   pend_entry_t     r_mem [DEPTH];
   logic [PtrW-1:0] r_wr_ptr;
   logic [PtrW-1:0] r_rd_ptr;
   logic [PtrW:0]   r_count;

   // Storage needs no reset; validity is tracked by r_count alone.
   always_ff @(posedge CLK) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= '{src: i_src, addr: i_addr};
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_full      = (r_count == (PtrW + 1)'(DEPTH));
   assign o_empty     = (r_count == '0);
   assign o_head_src  = r_mem[r_rd_ptr].src;
   assign o_head_addr = r_mem[r_rd_ptr].addr;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction reads and data reads/writes, routing
// read responses back in order. Define MEM_ARB_STARVE_GUARD_EN for the starvation guard.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned PEND_DEPTH   = 4,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        INST_RDEN,
   input  logic [31:0] INST_RIADDR,
   output logic        INST_RVALID,
   output logic [31:0] INST_ROADDR,
   output logic [31:0] INST_RDATA,
   input  logic        DATA_RDEN,
   input  logic [31:0] DATA_RIADDR,
   output logic        DATA_RVALID,
   output logic [31:0] DATA_ROADDR,
   output logic [31:0] DATA_RDATA,
   input  logic        DATA_WREN,
   input  logic [31:0] DATA_WADDR,
   input  logic [31:0] DATA_WDATA,
   output logic        MEM_WAIT,
   output logic        M_RDEN,
   output logic [31:0] M_RADDR,
   input  logic        M_RREADY,
   input  logic        M_RVALID,
   input  logic [31:0] M_RDATA,
   output logic        M_WREN,
   output logic [31:0] M_WADDR,
   output logic [31:0] M_WDATA,
   input  logic        M_WREADY,
   output logic        ERR_ORPHAN
);

   arb_state_e  r_state;
   logic        r_m_rden, r_m_wren;
   logic [31:0] r_m_raddr, r_m_waddr, r_m_wdata;
   logic        r_inst_rvalid, r_data_rvalid, r_err_orphan;
   logic [31:0] r_inst_roaddr, r_inst_rdata, r_data_roaddr, r_data_rdata;

   logic        w_fifo_full, w_fifo_empty, w_head_src;
   logic [31:0] w_head_addr;
   logic        w_pop, w_orphan, w_rd_ok, w_grant_ok, w_force_inst;
   logic        w_gnt_wr, w_gnt_dr, w_gnt_ir, w_push, w_push_src;
   logic [31:0] w_push_addr;

   assign w_pop    = M_RVALID & ~w_fifo_empty;
   assign w_orphan = M_RVALID & w_fifo_empty;
   // A response popping this cycle frees the slot a new read would take.
   assign w_rd_ok  = ~w_fifo_full | w_pop;

   always_comb begin
      w_grant_ok = 1'b0;
      case (r_state)
         IDLE:    w_grant_ok = 1'b1;
         RD_REQ:  w_grant_ok = M_RREADY;
         WR_REQ:  w_grant_ok = M_WREADY;
         default: w_grant_ok = 1'b0;
      endcase
   end

   always_comb begin
      w_gnt_wr = 1'b0;
      w_gnt_dr = 1'b0;
      w_gnt_ir = 1'b0;
      if (RST && w_grant_ok) begin
         if (w_force_inst && INST_RDEN && w_rd_ok) begin
            w_gnt_ir = 1'b1;
         end else if (DATA_WREN) begin
            w_gnt_wr = 1'b1;
         end else if (DATA_RDEN && w_rd_ok) begin
            w_gnt_dr = 1'b1;
         end else if (INST_RDEN && w_rd_ok) begin
            w_gnt_ir = 1'b1;
         end
      end
   end

   assign MEM_WAIT    = ~RST | (INST_RDEN & ~w_gnt_ir) | (DATA_RDEN & ~w_gnt_dr)
                        | (DATA_WREN & ~w_gnt_wr);
   assign w_push      = w_gnt_ir | w_gnt_dr;
   assign w_push_src  = w_gnt_dr ? SRC_DATA : SRC_INST;
   assign w_push_addr = w_gnt_dr ? DATA_RIADDR : INST_RIADDR;

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
   localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

   logic [StarveW-1:0] r_starve_cnt;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_starve_cnt <= '0;
      end else if (!INST_RDEN || w_gnt_ir) begin
         r_starve_cnt <= '0;
      end else if (r_starve_cnt != StarveMax) begin
         r_starve_cnt <= r_starve_cnt + 1'b1;
      end
   end

   assign w_force_inst = (r_starve_cnt == StarveMax);
`else
   assign w_force_inst = 1'b0;
`endif

   mem_arb_pend_fifo #(
      .DEPTH(PEND_DEPTH)
   ) u_pend_fifo (
      .CLK         (CLK),
      .RST         (RST),
      .i_push      (w_push),
      .i_src       (w_push_src),
      .i_addr      (w_push_addr),
      .i_pop       (w_pop),
      .o_full      (w_fifo_full),
      .o_empty     (w_fifo_empty),
      .o_head_src  (w_head_src),
      .o_head_addr (w_head_addr)
   );

   // Request side: outputs stay put until the memory accepts, then the next grant loads.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_state   <= IDLE;
         r_m_rden  <= 1'b0;
         r_m_wren  <= 1'b0;
         r_m_raddr <= '0;
         r_m_waddr <= '0;
         r_m_wdata <= '0;
      end else if (w_grant_ok) begin
         r_state  <= IDLE;
         r_m_rden <= 1'b0;
         r_m_wren <= 1'b0;
         if (w_gnt_wr) begin
            r_state   <= WR_REQ;
            r_m_wren  <= 1'b1;
            r_m_waddr <= DATA_WADDR;
            r_m_wdata <= DATA_WDATA;
         end else if (w_push) begin
            r_state   <= RD_REQ;
            r_m_rden  <= 1'b1;
            r_m_raddr <= w_push_addr;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_inst_rvalid <= 1'b0;
         r_inst_roaddr <= '0;
         r_inst_rdata  <= '0;
         r_data_rvalid <= 1'b0;
         r_data_roaddr <= '0;
         r_data_rdata  <= '0;
         r_err_orphan  <= 1'b0;
      end else begin
         r_inst_rvalid <= w_pop & (w_head_src == SRC_INST);
         r_data_rvalid <= w_pop & (w_head_src == SRC_DATA);
         if (w_pop && (w_head_src == SRC_INST)) begin
            r_inst_roaddr <= w_head_addr;
            r_inst_rdata  <= M_RDATA;
         end
         if (w_pop && (w_head_src == SRC_DATA)) begin
            r_data_roaddr <= w_head_addr;
            r_data_rdata  <= M_RDATA;
         end
         if (w_orphan) begin
            r_err_orphan <= 1'b1;
         end
      end
   end

   assign M_RDEN      = r_m_rden;
   assign M_RADDR     = r_m_raddr;
   assign M_WREN      = r_m_wren;
   assign M_WADDR     = r_m_waddr;
   assign M_WDATA     = r_m_wdata;
   assign INST_RVALID = r_inst_rvalid;
   assign INST_ROADDR = r_inst_roaddr;
   assign INST_RDATA  = r_inst_rdata;
   assign DATA_RVALID = r_data_rvalid;
   assign DATA_ROADDR = r_data_roaddr;
   assign DATA_RDATA  = r_data_rdata;
   assign ERR_ORPHAN  = r_err_orphan;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one memory port between the core's instruction-read channel and data read/write channel. Sits between the core and the external memory/bus. Grants one request at a time and holds the memory-side request until the memory accepts it. Tracks outstanding reads in order so each read response is returned to the channel that issued it, and stalls the core through `MEM_WAIT`.

## Interface
- `PEND_DEPTH`, 4: maximum outstanding reads tracked; power of two, ≥2.
- `STARVE_LIMIT`, 8: consecutive lost cycles before an instruction read is forced to win.
- `CLK` in 1: clock; all state updates on the rising edge.
- `RST` in 1: reset, synchronous, active-low.
- `INST_RDEN` in 1, `INST_RIADDR` in 32: instruction read request; held by the core while `MEM_WAIT`=1.
- `INST_RVALID` out 1, `INST_ROADDR` out 32, `INST_RDATA` out 32: instruction read response.
- `DATA_RDEN` in 1, `DATA_RIADDR` in 32: data read request.
- `DATA_RVALID` out 1, `DATA_ROADDR` out 32, `DATA_RDATA` out 32: data read response.
- `DATA_WREN` in 1, `DATA_WADDR` in 32, `DATA_WDATA` in 32: data write request.
- `MEM_WAIT` out 1: high when any asserted core request is not granted this cycle.
- `M_RDEN` out 1, `M_RADDR` out 32, `M_RREADY` in 1: memory read request and acceptance.
- `M_RVALID` in 1, `M_RDATA` in 32: memory read response; in order, at least 1 cycle after acceptance.
- `M_WREN` out 1, `M_WADDR` out 32, `M_WDATA` out 32, `M_WREADY` in 1: memory write request and acceptance.
- `ERR_ORPHAN` out 1: sticky; set when `M_RVALID` arrives while the pending FIFO is empty.

## Operation
- **FSM states**
  - `IDLE`: no memory request is outstanding on the request side.
  - `RD_REQ`: `M_RDEN`=1, waiting for `M_RREADY`.
  - `WR_REQ`: `M_WREN`=1, waiting for `M_WWREADY`.
- **Grant point**: a grant is made in `IDLE`, or in `RD_REQ`/`WR_REQ` in the cycle that `M_RREADY`/`M_WREADY`=1. This allows back-to-back requests.
- **Priority**
  - Default order: write > data read > instruction read.
  - Starved instruction read: wins over both when `starve_cnt` == `STARVE_LIMIT`.
- **Read eligibility**: a read is grantable only if the pending FIFO is not full. A FIFO pop in the same cycle counts as a free slot.
- **Effect of a grant**
  - The granted channel sees `MEM_WAIT`=0 that cycle, so the request is consumed.
  - The address/data are registered onto the `M_*` outputs next cycle.
- **Read grant**: pushes {source bit, address} into the pending FIFO.
- **Write grant**: does not use the FIFO; the write completes on `M_WREADY`.
- **Response routing**
  - On `M_RVALID`, the FIFO head is popped.
  - The registered response is presented on `INST_*` or `DATA_*` according to the source bit.
  - `*_ROADDR` comes from the FIFO, not from memory.
- **Orphan response**: `M_RVALID` with the FIFO empty is dropped and sets `ERR_ORPHAN`, which is cleared only by reset.
- **Starvation counter**
  - Increments (saturating) each cycle `INST_RDEN`=1 is not granted.
  - Clears on an instruction grant or when `INST_RDEN`=0.
  - Width is `$clog2(STARVE_LIMIT+1)`.
- **FIFO arithmetic**
  - Read/write pointers are `$clog2(PEND_DEPTH)` bits and wrap naturally.
  - Count is one bit wider.
  - Full when count == `PEND_DEPTH`; empty when count == 0.

## Timing
- **Reset** (`RST`=0 at a clock edge):
  - FSM returns to `IDLE`; FIFO and `starve_cnt` clear.
  - All registered outputs go to 0, including `ERR_ORPHAN`.
  - `MEM_WAIT` is forced to 1 while `RST`=0.
- **Reset mid-transaction**: any request in flight is abandoned. Memory shares `RST`, so no stale responses return.
- **Request latency**: a grant in cycle t drives `M_RDEN`/`M_WREN` in t+1. The signal stays high until the cycle `M_*READY`=1 inclusive.
- **Response latency**: `M_RVALID` in cycle t gives `INST_RVALID`/`DATA_RVALID` for exactly one cycle at t+1.
- **Simultaneous events**: a push and a pop in the same cycle leave count unchanged; this is legal even when full.
- **Throughput**: one request per cycle when `M_*READY` is tied high.

## Configuration
- **Macro**: `MEM_ARB_STARVE_GUARD_EN`.
- **Defined**: the starvation counter and the forced instruction grant are present.
- **Undefined**: strict fixed priority (write > data read > instruction read). `starve_cnt` is not instantiated and `STARVE_LIMIT` is ignored.

## Structure
- **Shared package `mem_arb_pkg`** holds:
  - the FSM state enum (`IDLE`, `RD_REQ`, `WR_REQ`);
  - the source encoding (`SRC_INST`=0, `SRC_DATA`=1);
  - the pending-entry struct {src, addr[31:0]}.
- **Sub-module `mem_arb_pend_fifo`**: a synchronous FIFO of `PEND_DEPTH` entries with push, pop, full, empty and head outputs.

## Test plan
- Reset, then idle → all outputs 0; `MEM_WAIT`=0 with no requests.
- Simultaneous `DATA_WREN` (0x100) and `INST_RDEN` (0x2000_0000), `M_*READY`=1 → write issued first; inst read issued the next cycle; `MEM_WAIT` high for inst in the first cycle.
- Data read 0x40 then inst read 0x2000_0004; memory returns 0xAAAA, then 0xBBBB → `DATA_RDATA`=0xAAAA with `DATA_ROADDR`=0x40, then `INST_RDATA`=0xBBBB with `INST_ROADDR`=0x2000_0004.
- 4 reads issued with no `M_RVALID` (`PEND_DEPTH`=4) → 5th read stalled (`MEM_WAIT`=1) until the first `M_RVALID`, then granted the same cycle.
- With `MEM_ARB_STARVE_GUARD_EN`, continuous `DATA_RDEN` plus `INST_RDEN` → instruction read granted in the 9th cycle.
- `M_RVALID` with an empty FIFO → `ERR_ORPHAN`=1, no `*_RVALID`; cleared only by `RST`=0.
